// File: rtl/rf_pkg.sv
// Shared constants and state encoding for the register-file port arbiter.
package rf_pkg;
  localparam int RF_XLEN = 32;
  localparam int RF_AW   = 5;
  localparam logic [RF_AW-1:0] X0 = '0;
  typedef enum logic {ARB, CLEAR} arb_state_e;
endpackage

// File: rtl/rf_clear_seq.sv
// Clear sweep sequencer: walks x1..x(2^AW-1), one index per cycle.
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int AW = RF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic [AW-1:0] idx,
  output logic          last
);

  assign last = busy && (idx == '1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy <= 1'b0;
      idx  <= '0;
    end else if (busy) begin
      if (last) busy <= 1'b0;
      idx <= idx + AW'(1);
    end else if (start) begin
      busy <= 1'b1;
      idx  <= AW'(1);
    end
  end

endmodule

// File: rtl/rf_port_arbiter.sv
// Shares a single-port register file between writeback and decode.
// Optional clear sweep enabled by defining RFARB_CLEAR_EN.
module rf_port_arbiter
  import rf_pkg::*;
#(
  parameter int XLEN         = RF_XLEN,
  parameter int AW           = RF_AW,
  parameter int MAX_WR_BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [AW-1:0]   wr_rd,
  input  logic [XLEN-1:0] wr_data,
  input  logic            rd_valid,
  output logic            rd_ready,
  input  logic [AW-1:0]   rd_rs1,
  input  logic [AW-1:0]   rd_rs2,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rs1_data,
  output logic [XLEN-1:0] rsp_rs2_data,
  output logic            rf_read,
  output logic [AW-1:0]   rf_rd,
  output logic [AW-1:0]   rf_rs1,
  output logic [AW-1:0]   rf_rs2,
  output logic [XLEN-1:0] rf_data_in,
  input  logic [XLEN-1:0] rf_rs1_out,
  input  logic [XLEN-1:0] rf_rs2_out
`ifdef RFARB_CLEAR_EN
  ,
  input  logic            clr_req,
  output logic            clr_busy
`endif
);

  localparam int BW = 4;
  localparam logic [BW-1:0] BMAX = BW'(MAX_WR_BURST);

  arb_state_e    state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          rsp_q, z1_q, z2_q;
  logic          wr_go, rd_go;
  logic          clr_start;

`ifdef RFARB_CLEAR_EN
  logic [AW-1:0] clr_idx;
  logic          clr_last;

  assign clr_start = rst && (state_q == ARB) && clr_req;

  rf_clear_seq #(.AW(AW)) u_clr (
    .clk   (clk),
    .rst   (rst),
    .start (clr_start),
    .busy  (clr_busy),
    .idx   (clr_idx),
    .last  (clr_last)
  );
`else
  assign clr_start = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    burst_d    = burst_q;
    wr_go      = 1'b0;
    rd_go      = 1'b0;
    rf_read    = 1'b1;
    rf_rd      = wr_rd;
    rf_data_in = wr_data;
    rf_rs1     = rd_rs1;
    rf_rs2     = rd_rs2;
    if (rst) begin
      unique case (state_q)
        ARB: begin
          if (clr_start) begin
            state_d = CLEAR;
          end else if (rd_valid &&
                       (!wr_valid || burst_q == BMAX)) begin
            rd_go = 1'b1;
          end else if (wr_valid) begin
            wr_go = 1'b1;
          end
          rf_read = !(wr_go && wr_rd != AW'(X0));
        end
`ifdef RFARB_CLEAR_EN
        CLEAR: begin
          rf_read    = 1'b0;
          rf_rd      = clr_idx;
          rf_data_in = '0;
          if (clr_last) state_d = ARB;
        end
`endif
        default: state_d = ARB;
      endcase
      // Starvation counter only tracks writes that overtake a waiting read
      if (!rd_valid || rd_go)
        burst_d = '0;
      else if (wr_go && burst_q != BMAX)
        burst_d = burst_q + BW'(1);
    end
  end

  assign wr_ready = wr_go;
  assign rd_ready = rd_go;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ARB;
      burst_q <= '0;
      rsp_q   <= 1'b0;
      z1_q    <= 1'b0;
      z2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      rsp_q   <= rd_go;
      z1_q    <= (rd_rs1 == AW'(X0));
      z2_q    <= (rd_rs2 == AW'(X0));
    end
  end

  // A response in flight is dropped as soon as reset is seen
  assign rsp_valid    = rst && rsp_q;
  assign rsp_rs1_data = (rsp_valid && !z1_q) ? rf_rs1_out : '0;
  assign rsp_rs2_data = (rsp_valid && !z2_q) ? rf_rs2_out : '0;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Bench for rf_port_arbiter: file model, vector table, sequences, random.
// Clear-sweep checks are compiled when RFARB_CLEAR_EN is defined.
module tb_rf_port_arbiter;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid, wr_ready, rd_valid, rd_ready;
  logic [4:0]  wr_rd, rd_rs1, rd_rs2;
  logic [31:0] wr_data;
  logic        rsp_valid;
  logic [31:0] rsp_rs1_data, rsp_rs2_data;
  logic        rf_read;
  logic [4:0]  rf_rd, rf_rs1, rf_rs2;
  logic [31:0] rf_data_in, rf_rs1_out, rf_rs2_out;
`ifdef RFARB_CLEAR_EN
  logic        clr_req, clr_busy;
`endif

  always #5 clk = ~clk;

  rf_port_arbiter #(.XLEN(32), .AW(5), .MAX_WR_BURST(MAXB)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_rd        (wr_rd),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_rs1       (rd_rs1),
    .rd_rs2       (rd_rs2),
    .rsp_valid    (rsp_valid),
    .rsp_rs1_data (rsp_rs1_data),
    .rsp_rs2_data (rsp_rs2_data),
    .rf_read      (rf_read),
    .rf_rd        (rf_rd),
    .rf_rs1       (rf_rs1),
    .rf_rs2       (rf_rs2),
    .rf_data_in   (rf_data_in),
    .rf_rs1_out   (rf_rs1_out),
    .rf_rs2_out   (rf_rs2_out)
`ifdef RFARB_CLEAR_EN
    ,
    .clr_req      (clr_req),
    .clr_busy     (clr_busy)
`endif
  );

  function automatic logic [31:0] f_init(int i);
    return 32'hA500_0000 | (i * 32'h0101);
  endfunction

  // Register file model; x0 deliberately holds a nonzero value
  logic [31:0] fmem [32];
  logic        tb_load;
  always @(posedge clk) begin
    if (tb_load) begin
      for (int i = 0; i < 32; i++) fmem[i] <= f_init(i);
    end else if (!rf_read) begin
      fmem[rf_rd] <= rf_data_in;
    end else begin
      rf_rs1_out <= fmem[rf_rs1];
      rf_rs2_out <= fmem[rf_rs2];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model state
  logic [31:0] ref_regs [32];
  int          m_burst;
  bit          m_pend;
  logic [31:0] m_r1, m_r2;
  int          m_clr;

  bit          cap_wr, cap_rd, cap_rf, cap_rsp, cap_busy;
  logic [31:0] cap_d1, cap_d2;

  task automatic cyc(string tag);
    bit ewr, erd, erf, ersp, blk;
    @(negedge clk);
    blk = (m_clr > 0);
`ifdef RFARB_CLEAR_EN
    blk = blk || (clr_req === 1'b1);
`endif
    erd  = rst && !blk && rd_valid && (!wr_valid || m_burst >= MAXB);
    ewr  = rst && !blk && wr_valid && !erd;
    erf  = !(ewr && wr_rd != 0) && !(rst && m_clr > 0);
    ersp = rst && m_pend;
    cap_wr  = wr_ready;
    cap_rd  = rd_ready;
    cap_rf  = rf_read;
    cap_rsp = rsp_valid;
    cap_d1  = rsp_rs1_data;
    cap_d2  = rsp_rs2_data;
    cap_busy = 1'b0;
    chk({tag, " wr_ready"}, 32'(wr_ready), 32'(ewr));
    chk({tag, " rd_ready"}, 32'(rd_ready), 32'(erd));
    chk({tag, " rf_read"}, 32'(rf_read), 32'(erf));
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(ersp));
    if (ersp) begin
      chk({tag, " rs1_data"}, rsp_rs1_data, m_r1);
      chk({tag, " rs2_data"}, rsp_rs2_data, m_r2);
    end
`ifdef RFARB_CLEAR_EN
    cap_busy = clr_busy;
    chk({tag, " clr_busy"}, 32'(clr_busy), 32'(m_clr > 0));
`endif
    @(posedge clk);
    if (!rst) begin
      m_burst = 0;
      m_pend  = 1'b0;
      m_clr   = 0;
    end else begin
      m_pend = erd;
      if (erd) begin
        m_r1 = ref_regs[rd_rs1];
        m_r2 = ref_regs[rd_rs2];
      end
      if (ewr && wr_rd != 0) ref_regs[wr_rd] = wr_data;
      if (!rd_valid || erd) m_burst = 0;
      else if (ewr && m_burst < MAXB) m_burst = m_burst + 1;
`ifdef RFARB_CLEAR_EN
      if (m_clr > 0) begin
        m_clr = m_clr - 1;
      end else if (clr_req) begin
        m_clr = 31;
        for (int i = 1; i < 32; i++) ref_regs[i] = '0;
      end
`endif
    end
    #1;
  endtask

  task automatic idle_in();
    wr_valid = 1'b0; rd_valid = 1'b0;
    wr_rd = '0; wr_data = '0; rd_rs1 = '0; rd_rs2 = '0;
  endtask

  typedef struct {
    bit          wv;
    logic [4:0]  wrd;
    logic [31:0] wd;
    bit          rv;
    logic [4:0]  r1, r2;
    bit          ewr, erd, erf, ersp;
    logic [31:0] e1, e2;
  } vec_t;

  vec_t tbl [11];
  logic [31:0] snap [32];
  int bad, busy_n;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0, 0, 0,            0, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[1]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0,            1, 5, 0, 0, 1, 1, 0, 0, 0};
    tbl[3]  = '{0, 0, 0,            0, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF, 0};
    tbl[4]  = '{1, 0, 32'h1234,     0, 0, 0, 1, 0, 1, 0, 0, 0};
    tbl[5]  = '{0, 0, 0,            1, 0, 5, 0, 1, 1, 0, 0, 0};
    tbl[6]  = '{0, 0, 0,            0, 0, 0, 0, 0, 1, 1, 0, 32'hDEADBEEF};
    tbl[7]  = '{1, 7, 32'h11,       1, 7, 5, 1, 0, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 0,            1, 7, 5, 0, 1, 1, 0, 0, 0};
    tbl[9]  = '{1, 3, 32'h33,       1, 3, 7, 1, 0, 0, 1, 32'h11, 32'hDEADBEEF};
    tbl[10] = '{0, 0, 0,            0, 0, 0, 0, 0, 1, 0, 0, 0};

    for (int i = 0; i < 32; i++) ref_regs[i] = (i == 0) ? '0 : f_init(i);
    m_burst = 0; m_pend = 0; m_clr = 0; m_r1 = '0; m_r2 = '0;
`ifdef RFARB_CLEAR_EN
    clr_req = 1'b0;
`endif

    // Reset with both requesters active
    rst = 1'b0; tb_load = 1'b1;
    idle_in();
    wr_valid = 1'b1; rd_valid = 1'b1; wr_rd = 5'd3; wr_data = 32'h77;
    #1;
    cyc("reset");
    chk("reset wr_ready", 32'(cap_wr), 0);
    chk("reset rd_ready", 32'(cap_rd), 0);
    chk("reset rf_read", 32'(cap_rf), 1);
    cyc("reset2");
    rst = 1'b1; tb_load = 1'b0;
    idle_in();
    cyc("post_reset");
    chk("reset rsp_valid", 32'(cap_rsp), 0);
    chk("reset rsp_data", cap_d1 | cap_d2, 0);

    // Idle: no writes reach the file
    for (int i = 0; i < 32; i++) snap[i] = fmem[i];
    for (int i = 0; i < 10; i++) begin
      cyc("idle");
      chk("idle rf_read", 32'(cap_rf), 1);
    end
    bad = 0;
    for (int i = 0; i < 32; i++) if (fmem[i] !== snap[i]) bad++;
    chk("idle mem_changed", bad, 0);

    // Directed vectors
    for (int i = 0; i < 11; i++) begin
      wr_valid = tbl[i].wv; wr_rd = tbl[i].wrd; wr_data = tbl[i].wd;
      rd_valid = tbl[i].rv; rd_rs1 = tbl[i].r1; rd_rs2 = tbl[i].r2;
      cyc("vec");
      chk($sformatf("vec%0d wr_ready", i), 32'(cap_wr), 32'(tbl[i].ewr));
      chk($sformatf("vec%0d rd_ready", i), 32'(cap_rd), 32'(tbl[i].erd));
      chk($sformatf("vec%0d rf_read", i), 32'(cap_rf), 32'(tbl[i].erf));
      chk($sformatf("vec%0d rsp_valid", i), 32'(cap_rsp), 32'(tbl[i].ersp));
      if (tbl[i].ersp) begin
        chk($sformatf("vec%0d rs1", i), cap_d1, tbl[i].e1);
        chk($sformatf("vec%0d rs2", i), cap_d2, tbl[i].e2);
      end
    end

    // Write burst vs waiting read: W W W W R repeating
    wr_valid = 1'b1; rd_valid = 1'b1; rd_rs1 = 5'd8; rd_rs2 = 5'd9;
    for (int i = 0; i < 15; i++) begin
      wr_rd = 5'(8 + i % 4); wr_data = 32'(i) + 32'hB000;
      cyc("burst");
      chk($sformatf("burst%0d rd_ready", i), 32'(cap_rd), 32'(i % 5 == 4));
      chk($sformatf("burst%0d wr_ready", i), 32'(cap_wr), 32'(i % 5 != 4));
    end
    idle_in();
    cyc("burst_end");

    // Reset between read grant and response drops the response
    rd_valid = 1'b1; rd_rs1 = 5'd8;
    cyc("rstmid_grant");
    chk("rstmid grant", 32'(cap_rd), 1);
    idle_in(); rst = 1'b0;
    cyc("rstmid_rst");
    chk("rstmid rsp_in_reset", 32'(cap_rsp), 0);
    rst = 1'b1;
    cyc("rstmid_after");
    chk("rstmid rsp_after", 32'(cap_rsp), 0);

    // Reset clears a partially built burst count
    wr_valid = 1'b1; rd_valid = 1'b1; wr_rd = 5'd12; wr_data = 32'hC0;
    for (int i = 0; i < 3; i++) cyc("preburst");
    rst = 1'b0;
    cyc("burst_rst");
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc("burst_after_rst");
      chk($sformatf("rstburst%0d rd_ready", i), 32'(cap_rd), 32'(i == 4));
    end
    idle_in();
    cyc("burst_after_end");

`ifdef RFARB_CLEAR_EN
    // Fill, sweep, then every register reads back zero
    for (int i = 1; i < 32; i++) begin
      wr_valid = 1'b1; wr_rd = 5'(i); wr_data = 32'(i) * 32'h1111 + 1;
      cyc("fill");
    end
    clr_req = 1'b1; rd_valid = 1'b1; rd_rs1 = 5'd1;
    cyc("clr_req");
    chk("clr wins wr", 32'(cap_wr), 0);
    chk("clr wins rd", 32'(cap_rd), 0);
    clr_req = 1'b0;
    busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      cyc("clearing");
      if (cap_busy) busy_n++;
    end
    idle_in();
    chk("clr busy_cycles", busy_n, 31);
    for (int i = 0; i < 32; i++) begin
      rd_valid = 1'b1; rd_rs1 = 5'(i); rd_rs2 = 5'(31 - i);
      cyc("clr_read");
      if (i > 0) chk($sformatf("clr rd%0d", i - 1), cap_d1 | cap_d2, 0);
    end
    idle_in();
    cyc("clr_done");
    chk("clr rd31", cap_d1 | cap_d2, 0);
`endif

    // Random traffic with occasional reset
    for (int i = 0; i < 1500; i++) begin
      rst      = ($urandom_range(63) != 0);
      wr_valid = ($urandom_range(99) < 60);
      rd_valid = ($urandom_range(99) < 55);
      wr_rd    = 5'($urandom_range(31));
      wr_data  = $urandom;
      rd_rs1   = 5'($urandom_range(31));
      rd_rs2   = 5'($urandom_range(31));
      cyc("rnd");
    end
    rst = 1'b1;
    idle_in();
    cyc("rnd_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
